// File: rtl/fb_addr_stream.sv
// Raster-order framebuffer address streamer.
// Walks H_ACTIVE x V_ACTIVE pixels on a valid/ready interface and emits the
// byte address of each pixel. The address applies pixel replication by
// 1x, 2x or 4x. Base and scale are captured when a frame starts.
module fb_addr_stream #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 32,
   parameter int BYTES_PX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [1:0]        scale,
   input  logic              ready,
   output logic              valid,
   output logic [ADDR_W-1:0] addr,
   output logic [9:0]        x,
   output logic [9:0]        y,
   output logic              eol,
   output logic              eof,
   output logic              busy,
   output logic              frame_done
);

   localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
   localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [1:0]        scale_q, scale_d;
   logic [ADDR_W-1:0] addr_d;
   logic [9:0]        x_d, y_d, nx, ny;
   logic              valid_d, busy_d, eol_d, eof_d, done_d;
   logic              accept;

   // Byte address of pixel (cx,cy). Scale s is already clamped to 0..2.
   function automatic logic [ADDR_W-1:0] calc_addr(input logic [9:0] cx,
                                                   input logic [9:0] cy,
                                                   input logic [ADDR_W-1:0] b,
                                                   input logic [1:0] s);
      logic [ADDR_W-1:0] stride, row, col;
      stride = ADDR_W'(H_ACTIVE) >> s;
      row    = ADDR_W'(cy >> s);
      col    = ADDR_W'(cx >> s);
      return b + (row * stride + col) * ADDR_W'(BYTES_PX);
   endfunction

   assign accept = valid && ready;

   // Next counter position in raster order after the current beat.
   always_comb begin
      nx = x + 10'd1;
      ny = y;
      if (eol) begin
         nx = '0;
         ny = y + 10'd1;
      end
   end

   // Next-state and next-output logic; all outputs are registered below.
   always_comb begin
      state_d = state;
      base_d  = base_q;
      scale_d = scale_q;
      addr_d  = addr;
      x_d     = x;
      y_d     = y;
      eol_d   = eol;
      eof_d   = eof;
      valid_d = valid;
      busy_d  = busy;
      done_d  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               base_d  = base;
               scale_d = (scale == 2'd3) ? 2'd2 : scale;
               x_d     = '0;
               y_d     = '0;
               addr_d  = base;
               eol_d   = (X_LAST == '0);
               eof_d   = (X_LAST == '0) && (Y_LAST == '0);
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            if (accept) begin
               if (eof) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  eol_d   = 1'b0;
                  eof_d   = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  x_d    = nx;
                  y_d    = ny;
                  addr_d = calc_addr(nx, ny, base_q, scale_q);
                  eol_d  = (nx == X_LAST);
                  eof_d  = (nx == X_LAST) && (ny == Y_LAST);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         base_q     <= '0;
         scale_q    <= '0;
         addr       <= '0;
         x          <= '0;
         y          <= '0;
         eol        <= 1'b0;
         eof        <= 1'b0;
         valid      <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         base_q     <= base_d;
         scale_q    <= scale_d;
         addr       <= addr_d;
         x          <= x_d;
         y          <= y_d;
         eol        <= eol_d;
         eof        <= eof_d;
         valid      <= valid_d;
         busy       <= busy_d;
         frame_done <= done_d;
      end
   end

endmodule

// File: tb/tb_fb_addr_stream.sv
// Testbench for fb_addr_stream. The first instance uses the default geometry
// and is checked against hand-computed addresses. The second instance is a
// small frame, checked against a queue of expected beats derived from the
// address formula.
module tb_fb_addr_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Default-geometry instance
   logic        d_rst, d_start, d_ready;
   logic [31:0] d_base;
   logic [1:0]  d_scale;
   logic        d_valid, d_eol, d_eof, d_busy, d_frame_done;
   logic [31:0] d_addr;
   logic [9:0]  d_x, d_y;

   fb_addr_stream dut_d (
      .clk(clk), .rst(d_rst), .start(d_start), .base(d_base), .scale(d_scale),
      .ready(d_ready), .valid(d_valid), .addr(d_addr), .x(d_x), .y(d_y),
      .eol(d_eol), .eof(d_eof), .busy(d_busy), .frame_done(d_frame_done)
   );

   // Small-frame instance (16x8, 16-bit addresses, 2 bytes per pixel)
   logic        s_rst, s_start, s_ready;
   logic [15:0] s_base;
   logic [1:0]  s_scale;
   logic        s_valid, s_eol, s_eof, s_busy, s_frame_done;
   logic [15:0] s_addr;
   logic [9:0]  s_x, s_y;

   fb_addr_stream #(.H_ACTIVE(16), .V_ACTIVE(8), .ADDR_W(16), .BYTES_PX(2)) dut_s (
      .clk(clk), .rst(s_rst), .start(s_start), .base(s_base), .scale(s_scale),
      .ready(s_ready), .valid(s_valid), .addr(s_addr), .x(s_x), .y(s_y),
      .eol(s_eol), .eof(s_eof), .busy(s_busy), .frame_done(s_frame_done)
   );

   typedef struct {
      logic [1:0]  scale;
      logic [31:0] base;
      int          tx;
      int          ty;
      logic [31:0] exp_addr;
      logic        exp_eol;
   } vec_t;

   typedef struct {
      int          x;
      int          y;
      logic [15:0] addr;
      logic        eol;
      logic        eof;
   } beat_t;

   vec_t  tbl[17];
   beat_t q[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Advance the default instance with ready high until beat (tx,ty) is shown.
   task automatic run_to(input int tx, input int ty);
      int n;
      n = 0;
      d_ready = 1'b1;
      while (!(d_valid && int'(d_x) == tx && int'(d_y) == ty) && n < 5000) begin
         step();
         n++;
      end
      if (n >= 5000) begin
         vectors++;
         miscompares++;
         $display("FAIL run_to timeout: got (%0d,%0d) expected (%0d,%0d)", d_x, d_y, tx, ty);
      end
   endtask

   task automatic restart_d(input logic [31:0] b, input logic [1:0] s);
      d_rst = 1'b1;
      step();
      d_rst   = 1'b0;
      d_base  = b;
      d_scale = s;
      d_start = 1'b1;
      d_ready = 1'b1;
      step();
      d_start = 1'b0;
   endtask

   initial begin
      int         cyc;
      int         fb, fs, se;
      logic       r;
      logic       b2b;
      beat_t      b;

      tbl[0]  = '{2'd0, 32'h39c, 0,   0, 32'h39c, 1'b0};
      tbl[1]  = '{2'd0, 32'h39c, 1,   0, 32'h3a0, 1'b0};
      tbl[2]  = '{2'd0, 32'h39c, 0,   1, 32'hd9c, 1'b0};
      tbl[3]  = '{2'd0, 32'h39c, 638, 0, 32'hd94, 1'b0};
      tbl[4]  = '{2'd0, 32'h39c, 639, 0, 32'hd98, 1'b1};
      tbl[5]  = '{2'd1, 32'h39c, 0,   0, 32'h39c, 1'b0};
      tbl[6]  = '{2'd1, 32'h39c, 1,   0, 32'h39c, 1'b0};
      tbl[7]  = '{2'd1, 32'h39c, 2,   0, 32'h3a0, 1'b0};
      tbl[8]  = '{2'd1, 32'h39c, 0,   1, 32'h39c, 1'b0};
      tbl[9]  = '{2'd1, 32'h39c, 0,   2, 32'h89c, 1'b0};
      tbl[10] = '{2'd2, 32'h39c, 3,   0, 32'h39c, 1'b0};
      tbl[11] = '{2'd2, 32'h39c, 4,   0, 32'h3a0, 1'b0};
      tbl[12] = '{2'd2, 32'h39c, 0,   4, 32'h61c, 1'b0};
      tbl[13] = '{2'd3, 32'h39c, 4,   0, 32'h3a0, 1'b0};
      tbl[14] = '{2'd3, 32'h39c, 0,   4, 32'h61c, 1'b0};
      tbl[15] = '{2'd0, 32'hfffffffc, 0, 0, 32'hfffffffc, 1'b0};
      tbl[16] = '{2'd0, 32'hfffffffc, 1, 0, 32'h00000000, 1'b0};

      d_rst = 1'b1; d_start = 1'b0; d_ready = 1'b0; d_base = '0; d_scale = '0;
      s_rst = 1'b1; s_start = 1'b0; s_ready = 1'b0; s_base = '0; s_scale = '0;
      step();
      step();

      // Reset values
      chk("reset valid/busy/done", {d_valid, d_busy, d_frame_done}, 0);
      chk("reset addr/x/y", {d_addr, d_x, d_y}, 0);
      chk("reset eol/eof", {d_eol, d_eof}, 0);
      d_rst = 1'b0;
      step();
      chk("idle no valid", {d_valid, d_busy}, 0);

      // First beat one edge after start
      d_base = 32'h39c; d_scale = 2'd0; d_start = 1'b1; d_ready = 1'b1;
      step();
      d_start = 1'b0;
      chk("first beat", {d_valid, d_busy, d_x, d_y, d_addr}, {1'b1, 1'b1, 10'd0, 10'd0, 32'h39c});

      // Backpressure at (3,0) for five cycles
      run_to(3, 0);
      d_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall hold", {d_valid, d_x, d_y, d_addr}, {1'b1, 10'd3, 10'd0, 32'h3a8});
      end
      d_ready = 1'b1;
      step();
      chk("resume beat", {d_valid, d_x, d_y, d_addr}, {1'b1, 10'd4, 10'd0, 32'h3ac});

      // Start and new base/scale mid-frame are ignored
      d_start = 1'b1; d_base = 32'h0; d_scale = 2'd2;
      step();
      d_start = 1'b0;
      chk("start ignored", {d_x, d_y, d_addr}, {10'd5, 10'd0, 32'h3b0});
      step();
      chk("base latched", {d_x, d_y, d_addr}, {10'd6, 10'd0, 32'h3b4});

      // Reset mid-frame at (10,2)
      run_to(10, 2);
      chk("at (10,2) addr", d_addr, 32'h39c + 32'((2 * 640 + 10) * 4));
      d_rst = 1'b1;
      step();
      d_rst = 1'b0;
      chk("rst abort outputs", {d_valid, d_busy, d_frame_done, d_x, d_y, d_addr, d_eol, d_eof}, 0);
      step();
      chk("rst no done pulse", {d_valid, d_frame_done}, 0);
      d_base = 32'h39c; d_scale = 2'd0; d_start = 1'b1;
      step();
      d_start = 1'b0;
      chk("restart after rst", {d_valid, d_x, d_y, d_addr}, {1'b1, 10'd0, 10'd0, 32'h39c});

      // Table of spot addresses
      for (int i = 0; i < 17; i++) begin
         restart_d(tbl[i].base, tbl[i].scale);
         run_to(tbl[i].tx, tbl[i].ty);
         chk($sformatf("tbl%0d addr", i), d_addr, tbl[i].exp_addr);
         chk($sformatf("tbl%0d eol", i), {d_eol, d_eof}, {tbl[i].exp_eol, 1'b0});
      end

      // Randomized full frames on the small instance
      s_rst = 1'b0;
      step();
      b2b = 1'b0;
      for (int f = 0; f < 8; f++) begin
         fb = int'($urandom_range(0, 65535));
         fs = int'($urandom_range(0, 3));
         se = (fs == 3) ? 2 : fs;
         q.delete();
         for (int yy = 0; yy < 8; yy++) begin
            for (int xx = 0; xx < 16; xx++) begin
               b.x    = xx;
               b.y    = yy;
               b.addr = 16'(fb + (((yy >> se) * (16 >> se)) + (xx >> se)) * 2);
               b.eol  = (xx == 15);
               b.eof  = (xx == 15) && (yy == 7);
               q.push_back(b);
            end
         end
         s_base  = 16'(fb);
         s_scale = 2'(fs);
         s_start = 1'b1;
         step();
         s_start = 1'b0;
         cyc = 0;
         while (q.size() > 0 && cyc < 4000) begin
            b = q[0];
            chk("rand beat",
                {s_valid, s_busy, s_frame_done, s_x, s_y, s_addr, s_eol, s_eof},
                {1'b1, 1'b1, 1'b0, 10'(b.x), 10'(b.y), b.addr, b.eol, b.eof});
            r       = ($urandom_range(0, 99) < 70);
            s_ready = r;
            s_base  = 16'($urandom);
            s_scale = 2'($urandom);
            s_start = ($urandom_range(0, 3) == 0);
            step();
            if (r) void'(q.pop_front());
            cyc++;
         end
         if (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rand frame timeout: got %0d beats left expected 0", q.size());
         end
         chk("frame_done pulse", {s_valid, s_busy, s_frame_done}, {1'b0, 1'b0, 1'b1});
         b2b = f[0];
         if (!b2b) begin
            s_start = 1'b0;
            step();
            chk("frame_done one cycle", {s_valid, s_busy, s_frame_done}, 0);
         end
      end
      s_start = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
